// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: double-buffered hex display with
// leading-zero blanking, PWM brightness and registered cathode/anode drive.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int COUNT_TO   = 100000,
  parameter int BRIGHT_W   = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic                    en_in,
  input  logic                    blank_lz_in,
  input  logic [BRIGHT_W-1:0]     bright_in,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_out
);

  localparam int CNT_W = (COUNT_TO > 1) ? $clog2(COUNT_TO) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(COUNT_TO - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        slot_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [BRIGHT_W-1:0]     phase;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_flag;

  logic                    slot_end;
  logic                    frame_wrap;
  logic                    load_acc;
  logic                    lit_now;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    blank_cur;
  logic                    zero_run;
  logic [6:0]              cat_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  assign slot_end   = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_end && (digit_idx == IDX_LAST);
  assign ready_out  = ~pend_flag;
  assign load_acc   = valid_in && ~pend_flag;
  assign lit_now    = en_in && (phase <= bright_in);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      slot_cnt  <= slot_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) phase <= '0;
    else        phase <= phase + BRIGHT_W'(1);
  end

  // Accept and transfer are mutually exclusive on pend_flag, so a load taken
  // in the wrap cycle itself waits for the following wrap.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      disp_val  <= '0;
      disp_dp   <= '0;
    end else if (load_acc) begin
      pend_val  <= val_in;
      pend_dp   <= dp_in;
      pend_flag <= 1'b1;
    end else if (frame_wrap && pend_flag) begin
      disp_val  <= pend_val;
      disp_dp   <= pend_dp;
      pend_flag <= 1'b0;
    end
  end

  // Walk from the most significant digit down so zero_run tells whether
  // every nibble at or above position i is zero.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    blank_cur = 1'b0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp_val[4*i +: 4] == 4'h0);
      if (digit_idx == IDX_W'(i)) begin
        cur_nib   = disp_val[4*i +: 4];
        cur_dp    = disp_dp[i];
        blank_cur = blank_lz_in && zero_run && (i != 0);
      end
    end
  end

  always_comb begin
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit_now && (digit_idx == IDX_W'(i))) an_next[i] = 1'b0;
    end
    cat_next = 7'h7F;
    dp_next  = 1'b1;
    if (en_in) begin
      cat_next = blank_cur ? 7'h7F : ~seg_decode(cur_nib);
      dp_next  = ~cur_dp;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cat_out   <= 7'h7F;
      dp_out    <= 1'b1;
      an_out    <= '1;
      frame_out <= 1'b0;
    end else begin
      cat_out   <= cat_next;
      dp_out    <= dp_next;
      an_out    <= an_next;
      frame_out <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: cycle-count reference model compared every
// cycle, plus directed literal checks on scan, load, blanking, PWM and reset.
module tb_sevenseg_scan_ctrl;

  localparam int ND = 4;
  localparam int CT = 4;
  localparam int BW = 2;
  localparam int FRAME = ND * CT;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [15:0]   val_in;
  logic [3:0]    dp_in;
  logic          valid_in;
  logic          ready_out;
  logic          en_in;
  logic          blank_lz_in;
  logic [1:0]    bright_in;
  logic [6:0]    cat_out;
  logic          dp_out;
  logic [3:0]    an_out;
  logic          frame_out;

  sevenseg_scan_ctrl #(.NUM_DIGITS(ND), .COUNT_TO(CT), .BRIGHT_W(BW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .val_in(val_in), .dp_in(dp_in),
    .valid_in(valid_in), .ready_out(ready_out), .en_in(en_in),
    .blank_lz_in(blank_lz_in), .bright_in(bright_in), .cat_out(cat_out),
    .dp_out(dp_out), .an_out(an_out), .frame_out(frame_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the scan is a pure function of cycles since reset.
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          m_cyc;
  logic [15:0] m_disp, m_pval;
  logic [3:0]  m_ddp, m_pdp;
  logic        m_pend;
  logic [6:0]  exp_cat;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_frame;

  initial begin
    int idx, ph;
    logic wrap, blank;
    logic [3:0] nib;
    forever begin
      @(posedge clk_in);
      if (rst_in) begin
        m_cyc = 0; m_disp = '0; m_ddp = '0; m_pval = '0; m_pdp = '0; m_pend = 1'b0;
        exp_cat = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_frame = 1'b0;
      end else begin
        idx   = (m_cyc / CT) % ND;
        ph    = m_cyc % (1 << BW);
        wrap  = (m_cyc % FRAME) == FRAME - 1;
        nib   = 4'((m_disp >> (4 * idx)) & 16'hF);
        blank = blank_lz_in && (idx > 0) && ((m_disp >> (4 * idx)) == 16'h0);
        exp_frame = wrap;
        exp_an  = (en_in && ph <= int'(bright_in)) ? (4'hF ^ (4'b0001 << idx)) : 4'hF;
        exp_cat = !en_in ? 7'h7F : (blank ? 7'h7F : (7'h7F ^ seg_tab[nib]));
        exp_dp  = !en_in ? 1'b1 : !m_ddp[idx];
        if (wrap && m_pend) begin
          m_disp = m_pval; m_ddp = m_pdp; m_pend = 1'b0;
        end else if (valid_in && !m_pend) begin
          m_pval = val_in; m_pdp = dp_in; m_pend = 1'b1;
        end
        m_cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        check("rst_an", an_out, 4'hF);
        check("rst_cat", cat_out, 7'h7F);
        check("rst_frame", frame_out, 1'b0);
        check("rst_ready", ready_out, 1'b1);
      end else begin
        check("mdl_an", an_out, exp_an);
        check("mdl_cat", cat_out, exp_cat);
        check("mdl_dp", dp_out, exp_dp);
        check("mdl_frame", frame_out, exp_frame);
        check("mdl_ready", ready_out, !m_pend);
      end
    end
  end

  task automatic sync_to(input int pos);
    int b = 0;
    do begin
      @(negedge clk_in);
      b++;
    end while ((m_cyc % FRAME) != pos && b < 3 * FRAME);
    if ((m_cyc % FRAME) != pos) begin
      n_checks++; n_fail++;
      $display("FAIL sync_timeout: got %0d expected %0d", m_cyc % FRAME, pos);
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d, input int pos);
    sync_to(pos);
    val_in = v; dp_in = d; valid_in = 1'b1;
    sync_to((pos + 1) % FRAME);
    valid_in = 1'b0;
  endtask

  initial begin
    int cnt_lit, cnt_cat;
    rst_in = 1'b1; val_in = '0; dp_in = '0; valid_in = 1'b0;
    en_in = 1'b1; blank_lz_in = 1'b0; bright_in = 2'd3;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_an", an_out, 4'hF);
    check("reset_dp", dp_out, 1'b1);
    @(posedge clk_in); #1 rst_in = 1'b0;
    @(negedge clk_in);
    check("post_rst_an", an_out, 4'hF);

    // Scan order and frame pulse
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_in);
      check("scan_an", an_out, 4'hF ^ (4'b0001 << (((k - 1) / CT) % ND)));
      check("scan_frame", frame_out, (k % FRAME) == 0);
    end

    // Mid-frame load
    load(16'h12AF, 4'b0100, 5);
    check("load_ready_low", ready_out, 1'b0);
    sync_to(13);
    check("load_old_an", an_out, 4'b0111);
    check("load_old_cat", cat_out, 7'h40);
    sync_to(1);
    check("load_d0_an", an_out, 4'b1110);
    check("load_d0_cat", cat_out, 7'h0E);
    check("load_ready_high", ready_out, 1'b1);
    sync_to(9);
    check("load_d2_cat", cat_out, 7'h24);
    check("load_d2_dp", dp_out, 1'b0);

    // Load in the wrap cycle, then a second request while busy
    sync_to(15);
    val_in = 16'h3456; dp_in = 4'b0001; valid_in = 1'b1;
    sync_to(0);
    check("coll_ready_low", ready_out, 1'b0);
    val_in = 16'h789A; dp_in = 4'b1111;
    sync_to(1);
    check("coll_still_old", cat_out, 7'h0E);
    sync_to(4);
    valid_in = 1'b0;
    sync_to(1);
    check("coll_new_cat", cat_out, 7'h02);
    check("coll_new_dp", dp_out, 1'b0);
    sync_to(5);
    check("coll_d1_cat", cat_out, 7'h7F ^ 7'h6D);

    // Leading-zero suppression
    blank_lz_in = 1'b1;
    load(16'h0005, 4'b0000, 5);
    sync_to(1);
    check("lz_d0", cat_out, 7'h12);
    sync_to(5);
    check("lz_d1", cat_out, 7'h7F);
    sync_to(9);
    check("lz_d2", cat_out, 7'h7F);
    sync_to(13);
    check("lz_d3", cat_out, 7'h7F);
    load(16'h0000, 4'b0000, 2);
    sync_to(1);
    check("lz_zero_d0", cat_out, 7'h40);
    sync_to(13);
    check("lz_zero_d3", cat_out, 7'h7F);

    // Brightness and enable
    bright_in = 2'd0;
    cnt_lit = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk_in);
      if (an_out != 4'hF) cnt_lit++;
    end
    check("bright0_lit_cycles", cnt_lit, 4);
    bright_in = 2'd3;
    en_in = 1'b0;
    @(negedge clk_in);
    cnt_lit = 0; cnt_cat = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk_in);
      if (an_out != 4'hF) cnt_lit++;
      if (cat_out != 7'h7F) cnt_cat++;
    end
    check("en0_an_dark", cnt_lit, 0);
    check("en0_cat_dark", cnt_cat, 0);
    en_in = 1'b1;

    // Randomised traffic against the model
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_in);
      valid_in    = ($urandom_range(0, 3) == 0);
      val_in      = 16'($urandom);
      dp_in       = 4'($urandom);
      blank_lz_in = 1'($urandom);
      bright_in   = 2'($urandom);
      en_in       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_in = 1'b1;
        @(posedge clk_in); #1 rst_in = 1'b0;
      end
    end

    // Async reset with a pending load
    valid_in = 1'b0; en_in = 1'b1; blank_lz_in = 1'b1; bright_in = 2'd3;
    sync_to(1);
    load(16'hBEEF, 4'b1010, 5);
    check("ar_pending", ready_out, 1'b0);
    sync_to(8);
    #1 rst_in = 1'b1;
    #1;
    check("ar_an", an_out, 4'hF);
    check("ar_cat", cat_out, 7'h7F);
    check("ar_dp", dp_out, 1'b1);
    check("ar_frame", frame_out, 1'b0);
    check("ar_ready", ready_out, 1'b1);
    @(posedge clk_in); @(posedge clk_in); #1 rst_in = 1'b0;
    sync_to(1);
    check("ar_d0_cat", cat_out, 7'h40);
    check("ar_d0_an", an_out, 4'b1110);
    sync_to(5);
    check("ar_d1_blank", cat_out, 7'h7F);
    sync_to(1);
    check("ar_lost_cat", cat_out, 7'h40);
    check("ar_lost_dp", dp_out, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (legal 1..16).
REQ-002 SHALL have parameter COUNT_TO, default 100000, clock cycles per digit slot (legal >=1).
REQ-003 SHALL have parameter BRIGHT_W, default 3, brightness control width (legal 1..8).
REQ-004 SHALL have port clk_in  input  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port val_in  input  4*NUM_DIGITS  hex nibbles, digit i = val_in[4i+3:4i].
REQ-007 SHALL have port dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-008 SHALL have port valid_in  input  1  request to load val_in/dp_in.
REQ-009 SHALL have port ready_out  output  1  load accepted when valid_in && ready_out.
REQ-010 SHALL have port en_in  input  1  0 = all digits dark.
REQ-011 SHALL have port blank_lz_in  input  1  1 = suppress leading zeros.
REQ-012 SHALL have port bright_in  input  BRIGHT_W  duty control.
REQ-013 SHALL have port cat_out  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 SHALL have port dp_out  output  1  decimal point cathode, active-low.
REQ-015 SHALL have port an_out  output  NUM_DIGITS  digit anodes, active-low, bit i = digit i.
REQ-016 SHALL have port frame_out  output  1  one-cycle pulse at frame wrap.

Function
REQ-017 SHALL hold slot counter 0..COUNT_TO-1; at COUNT_TO-1 it returns to 0 and digit index advances i -> i+1, NUM_DIGITS-1 -> 0.
REQ-018 SHALL pulse frame_out for the one cycle in which index wraps NUM_DIGITS-1 -> 0.
REQ-019 SHALL double-buffer: accepted load writes a pending register and sets pending flag; ready_out = ~pending.
REQ-020 SHALL copy pending to display register on frame wrap cycle only if pending was set before that cycle, then clear pending; ready_out rises the following cycle.
REQ-021 SHALL, on load accepted in the frame-wrap cycle itself, apply it at the next frame wrap (no same-cycle pass-through).
REQ-022 SHALL ignore valid_in while ready_out = 0; no overwrite of pending.
REQ-023 SHALL decode nibbles active-high 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71; cat_out = inverted pattern.
REQ-024 SHALL blank segments of digit i>0 when blank_lz_in = 1 and display nibbles i..NUM_DIGITS-1 all zero; digit 0 never blanked; dp unaffected.
REQ-025 SHALL run free BRIGHT_W-bit phase counter, +1 per cycle, wrapping; anode of current digit asserted only while phase <= bright_in (all-ones = 100%, 0 = 1/2^BRIGHT_W).
REQ-026 SHALL drive an_out all ones, cat_out 7'h7F, dp_out 1 when en_in = 0; scanning, counters and load handshake continue.
REQ-027 SHALL register cat_out, dp_out, an_out, frame_out: each reflects internal state of previous cycle (latency 1).
REQ-028 SHALL assert at most one an_out bit low in any cycle.

Reset
REQ-029 SHALL, while rst_in = 1, hold slot counter 0, index 0, phase 0, display and pending registers 0, pending flag 0.
REQ-030 SHALL reset outputs to ready_out 1, an_out all ones, cat_out 7'h7F, dp_out 1, frame_out 0, immediately without clock.
REQ-031 SHALL discard a pending load on reset mid-frame; first post-reset frame shows 0 on all digits (digit 0 shows "0" with blank_lz_in = 1).

Verification (NUM_DIGITS=4, COUNT_TO=4, BRIGHT_W=2, bright_in=3, en_in=1)
REQ-032 SHALL check scan: after reset release an_out sequence 1110,1101,1011,0111 each 4 cycles, frame_out every 16 cycles.
REQ-033 SHALL check load: val_in=16'h12AF, dp_in=4'b0100 accepted mid-frame -> ready_out 0, display unchanged until wrap, next frame digit0 cat_out 7'h0E, digit2 dp_out 0, ready_out 1 after wrap.
REQ-034 SHALL check collision: valid_in in frame-wrap cycle -> applied one frame later; second valid_in while ready_out=0 ignored.
REQ-035 SHALL check leading zeros: val_in=16'h0005, blank_lz_in=1 -> digits 3..1 cat_out 7'h7F, digit0 7'h12; val_in=16'h0000 -> digit0 shows 7'h40.
REQ-036 SHALL check brightness: bright_in=0 -> active anode low 1 of every 4 cycles; en_in=0 -> an_out 4'hF throughout.
REQ-037 SHALL check async reset asserted mid-slot with pending load -> outputs to reset values same cycle, pending lost.
